i2c_audio_codec_slave: RTL and testbench



---
 rtl/i2c_audio_codec_slave.sv | 180 ++++++++++++++++++
 tb/tb_i2c_audio_codec_slave.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_audio_codec_slave.sv
// I2C write-only target for the audio codec control port: device byte, then 7-bit index + 9-bit data.
// Optional feature: define I2C_AUDIO_SLAVE_RESET_REG_EN to make index 15 restore R0..R9 to defaults.
module i2c_audio_codec_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [3:0] iRD_ADDR,
    output logic [8:0] oRD_DATA,
    output logic       oWR_STB,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oACTIVE,
    output logic       oBUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_HI, S_ACK_H, S_LO, S_ACK_L, S_IGNORE
    } state_t;

    localparam logic [8:0] RST_VAL [10] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
    logic                   scl_prev_reg, sda_prev_reg;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] hi_reg, hi_next;
    logic       ack_reg, ack_next;
    logic       busy_reg, busy_next;
    logic       commit;

    logic       wr_stb_reg;
    logic [6:0] reg_addr_reg;
    logic [8:0] reg_data_reg;
    logic [8:0] regs_reg [10];
    logic       clear_all;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false START.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], I2C_SDAT};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'd0;
            hi_reg      <= 8'd0;
            ack_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            hi_reg      <= hi_next;
            ack_reg     <= ack_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        hi_next      = hi_reg;
        busy_next    = busy_reg;
        commit       = 1'b0;
        if (stop_det) begin
            state_next   = S_IDLE;
            bit_cnt_next = 4'd0;
            busy_next    = 1'b0;
        end else if (start_det) begin
            state_next   = S_ADDR;
            bit_cnt_next = 4'd0;
            busy_next    = 1'b1;
        end else begin
            case (state_reg)
                S_ADDR, S_HI, S_LO: begin
                    if (scl_rise && bit_cnt_reg != 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        // Byte complete: the ACK slot starts on this SCL fall.
                        bit_cnt_next = 4'd0;
                        if (state_reg == S_ADDR) begin
                            state_next = (shift_reg == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                        end else if (state_reg == S_HI) begin
                            hi_next    = shift_reg;
                            state_next = S_ACK_H;
                        end else begin
                            state_next = S_ACK_L;
                            commit     = 1'b1;
                        end
                    end
                end
                S_ACK_A: if (scl_fall) state_next = S_HI;
                S_ACK_H: if (scl_fall) state_next = S_LO;
                S_ACK_L: if (scl_fall) state_next = S_IGNORE;
                default: ;
            endcase
        end
        ack_next = (state_next == S_ACK_A) || (state_next == S_ACK_H) || (state_next == S_ACK_L);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_stb_reg   <= 1'b0;
            reg_addr_reg <= 7'd0;
            reg_data_reg <= 9'd0;
        end else begin
            wr_stb_reg <= commit;
            if (commit) begin
                reg_addr_reg <= hi_reg[7:1];
                reg_data_reg <= {hi_reg[0], shift_reg};
            end
        end
    end

`ifdef I2C_AUDIO_SLAVE_RESET_REG_EN
    assign clear_all = wr_stb_reg && (reg_addr_reg == 7'd15);
`else
    assign clear_all = 1'b0;
`endif

    // The register file is written from the latched commit, so reads see it the cycle after the strobe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 10; i++) regs_reg[i] <= RST_VAL[i];
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (clear_all)
                    regs_reg[i] <= RST_VAL[i];
                else if (wr_stb_reg && reg_addr_reg == 7'(i))
                    regs_reg[i] <= reg_data_reg;
            end
        end
    end

    always_comb begin
        oRD_DATA = 9'd0;
        for (int i = 0; i < 10; i++) begin
            if (iRD_ADDR == 4'(i)) oRD_DATA = regs_reg[i];
        end
    end

    assign I2C_SDAT  = ack_reg ? 1'b0 : 1'bz;
    assign oWR_STB   = wr_stb_reg;
    assign oREG_ADDR = reg_addr_reg;
    assign oREG_DATA = reg_data_reg;
    assign oACTIVE   = regs_reg[9][0];
    assign oBUSY     = busy_reg;

endmodule

// File: tb/tb_i2c_audio_codec_slave.sv
// Bench for i2c_audio_codec_slave: bit-banged I2C master, register-file model and per-cycle checker.
module tb_i2c_audio_codec_slave;
    localparam int Q = 8;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       hold_rd = 1'b0;
    logic       forbid_drive = 1'b0;
    logic       prev_stb = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         stb_count = 0;

    wire        sda_bus;
    logic [8:0] rd_data;
    logic       wr_stb, active, busy;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_audio_codec_slave dut (
        .iCLK(clk), .iRST_N(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sda_bus),
        .iRD_ADDR(rd_addr), .oRD_DATA(rd_data), .oWR_STB(wr_stb),
        .oREG_ADDR(reg_addr), .oREG_DATA(reg_data), .oACTIVE(active), .oBUSY(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed { logic [6:0] a; logic [8:0] d; } commit_t;
    logic [8:0] m_regs [10];
    commit_t    exp_q [$];

    function automatic logic [8:0] rst_val(input int i);
        case (i)
            0, 1: return 9'h097;
            2, 3: return 9'h079;
            4, 7: return 9'h00A;
            5:    return 9'h008;
            6:    return 9'h09F;
            default: return 9'h000;
        endcase
    endfunction

    task automatic model_reset_regs();
        for (int i = 0; i < 10; i++) m_regs[i] = rst_val(i);
    endtask

    task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
        if (a <= 7'd9) m_regs[a] = d;
`ifdef I2C_AUDIO_SLAVE_RESET_REG_EN
        else if (a == 7'd15) model_reset_regs();
`endif
    endtask

    function automatic logic [8:0] model_rd(input logic [3:0] a);
        return (a < 4'd10) ? m_regs[a] : 9'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (!hold_rd) rd_addr = 4'($urandom_range(0, 15));
    end

    always @(negedge clk) begin
        commit_t e;
        logic    skip;
        skip = 1'b0;
        if (!rst_n) begin
            check("rst_stb", wr_stb, 0);
            check("rst_reg_addr", reg_addr, 0);
            check("rst_reg_data", reg_data, 0);
            check("rst_busy", busy, 0);
            prev_stb = 1'b0;
        end else begin
            if (wr_stb) begin
                skip = 1'b1;
                stb_count++;
                check("stb_width", prev_stb, 0);
                check("stb_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("stb_reg_addr", reg_addr, e.a);
                    check("stb_reg_data", reg_data, e.d);
                    model_commit(e.a, e.d);
                end
            end
            prev_stb = wr_stb;
        end
        if (!skip) begin
            check("rd_data", rd_data, model_rd(rd_addr));
            check("active", active, m_regs[9][0]);
        end
        if (!m_low && forbid_drive) check("sda_undriven", sda_bus, 1);
    end

    // ---------------- bus master ----------------
    task automatic wq(input int n = 1);
        repeat (n * Q) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; wq(); scl = 1'b1; wq(2); scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        m_low = 1'b0; wq(); scl = 1'b1; wq();
        a = (sda_bus == 1'b0);
        wq(); scl = 1'b0; wq();
        check(nm, a, exp_ack);
    endtask

    task automatic start_cond();
        m_low = 1'b0; wq(); scl = 1'b1; wq(); m_low = 1'b1; wq(); scl = 1'b0; wq();
        check("busy_on", busy, 1);
    endtask

    task automatic stop_cond();
        m_low = 1'b1; wq(); scl = 1'b1; wq(); m_low = 1'b0; wq(2);
        check("busy_off", busy, 0);
    endtask

    task automatic xfer(input logic [7:0] dev, input logic [7:0] hi, input logic [7:0] lo,
                        input int nbytes, input logic do_stop);
        logic    acc;
        commit_t c;
        acc = (dev == 8'h34);
        forbid_drive = ~acc;
        start_cond();
        send_byte(dev, acc, "ack_dev");
        if (nbytes >= 2) send_byte(hi, acc, "ack_hi");
        if (nbytes >= 3) begin
            if (acc) begin
                c.a = hi[7:1];
                c.d = {hi[0], lo};
                exp_q.push_back(c);
            end
            send_byte(lo, acc, "ack_lo");
        end
        if (nbytes >= 4) send_byte(8'($urandom), 1'b0, "ack_extra");
        check("strobe_drained", exp_q.size(), 0);
        if (do_stop) stop_cond();
        forbid_drive = 1'b0;
    endtask

    task automatic check_reg(input string nm, input logic [3:0] idx, input logic [8:0] exp);
        hold_rd = 1'b1;
        @(posedge clk); #1;
        rd_addr = idx;
        @(negedge clk);
        check(nm, rd_data, exp);
        hold_rd = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        model_reset_regs();
        #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        check("rst_active", active, 0);
        #1 rst_n = 1'b1;
        wq(2);
        check_reg("rst_r0", 4'd0, 9'h097);
        check_reg("rst_r6", 4'd6, 9'h09F);
        check_reg("rst_r4", 4'd4, 9'h00A);

        // wrong device address: no ACK, no drive, no strobe
        s0 = stb_count;
        xfer(8'h36, 8'h08, 8'hD2, 3, 1'b1);
        check("bad_dev_strobes", stb_count - s0, 0);
        check_reg("bad_dev_r4", 4'd4, 9'h00A);

        // basic write to R4
        s0 = stb_count;
        xfer(8'h34, 8'h08, 8'hD2, 3, 1'b1);
        check("w4_strobes", stb_count - s0, 1);
        check("w4_reg_addr", reg_addr, 7'h04);
        check("w4_reg_data", reg_data, 9'h0D2);
        check_reg("w4_r4", 4'd4, 9'h0D2);

        // R9[0] drives oACTIVE, then index 15
        xfer(8'h34, 8'h12, 8'h01, 3, 1'b1);
        check("active_set", active, 1);
        xfer(8'h34, 8'h1E, 8'h00, 3, 1'b1);
        check("r15_reg_addr", reg_addr, 7'd15);
`ifdef I2C_AUDIO_SLAVE_RESET_REG_EN
        check("r15_active", active, 0);
        check_reg("r15_r4", 4'd4, 9'h00A);
`else
        check("r15_active", active, 1);
        check_reg("r15_r4", 4'd4, 9'h0D2);
`endif

        // truncated transfer is discarded
        s0 = stb_count;
        xfer(8'h34, 8'h0A, 8'h00, 2, 1'b1);
        check("trunc_strobes", stb_count - s0, 0);
        check_reg("trunc_r5", 4'd5, 9'h008);

        // repeated START abandons the partial transfer
        s0 = stb_count;
        xfer(8'h34, 8'h0A, 8'h00, 2, 1'b0);
        xfer(8'h34, 8'h0C, 8'h00, 3, 1'b1);
        check("rs_strobes", stb_count - s0, 1);
        check("rs_reg_addr", reg_addr, 7'h06);
        check("rs_reg_data", reg_data, 9'h000);

        // reset during the ACK of the index byte
        start_cond();
        send_byte(8'h34, 1'b1, "ack_dev");
        for (int i = 7; i >= 0; i--) put_bit(8'h08 >> i);
        m_low = 1'b0; wq();
        check("ackh_driven", sda_bus, 0);
        model_reset_regs();
        rst_n = 1'b0;
        #1 check("rst_sda_release", sda_bus, 1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        scl = 1'b1; wq(2);
        xfer(8'h34, 8'h00, 8'h17, 3, 1'b1);
        check_reg("post_rst_r0", 4'd0, 9'h017);

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            logic [7:0] dev, hi, lo;
            logic [6:0] a;
            int         nb;
            logic       stp;
            dev = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h34;
            a   = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
            hi  = {a, 1'($urandom)};
            lo  = 8'($urandom);
            nb  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 3;
            stp = (n == 23) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            xfer(dev, hi, lo, nb, stp);
        end
        wq(2);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
